// File: rtl/aud_recorder_if.sv
// Codec, control and SRAM write signals of the audio recorder.
// The slave view belongs to the recorder, the master view to its driver.
interface aud_recorder_if #(
   parameter int ADDR_W = 20
);
   logic              i_adclrck;
   logic              i_adcdat;
   logic              i_start;
   logic              i_pause;
   logic              i_stop;
   logic [ADDR_W-1:0] o_address;
   logic [15:0]       o_data;
   logic              o_valid;
   logic              o_busy;
   logic              o_full;

   modport slave (
      input  i_adclrck,
      input  i_adcdat,
      input  i_start,
      input  i_pause,
      input  i_stop,
      output o_address,
      output o_data,
      output o_valid,
      output o_busy,
      output o_full
   );

   modport master (
      output i_adclrck,
      output i_adcdat,
      output i_start,
      output i_pause,
      output i_stop,
      input  o_address,
      input  o_data,
      input  o_valid,
      input  o_busy,
      input  o_full
   );
endinterface

// File: rtl/aud_recorder.sv
// I2S right-channel capture: 16-bit MSB-first samples are written
// to SRAM one per LRCK period, with start/pause/stop and full control.
module aud_recorder #(
   parameter int              ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
   input  logic          i_bclk,
   input  logic          i_rst_n,
   aud_recorder_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RECV
   } state_t;

   state_t            state_q, state_d;
   logic              lrc_q, lrc_d;
   logic [15:0]       shift_q, shift_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] next_addr_q, next_addr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       data_q, data_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              full_q, full_d;
   logic              frame_start;

   // The frame-start edge is the I2S delay slot; its data bit is ignored.
   assign frame_start = ~lrc_q & bus.i_adclrck;

   always_comb begin
      state_d     = state_q;
      lrc_d       = bus.i_adclrck;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      next_addr_d = next_addr_q;
      addr_d      = addr_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      full_d      = full_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.i_start && !bus.i_stop) begin
               next_addr_d = '0;
               full_d      = 1'b0;
               state_d     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus.i_stop) begin
               state_d = S_IDLE;
            end else if (frame_start && !bus.i_pause) begin
               cnt_d   = 4'd15;
               state_d = S_RECV;
            end
         end
         S_RECV: begin
            if (bus.i_stop) begin
               state_d = S_IDLE;
            end else if (!bus.i_adclrck) begin
               state_d = S_WAIT;
            end else begin
               shift_d[cnt_q] = bus.i_adcdat;
               cnt_d          = cnt_q - 4'd1;
               if (cnt_q == 4'd0) begin
                  data_d  = {shift_q[15:1], bus.i_adcdat};
                  addr_d  = next_addr_q;
                  valid_d = 1'b1;
                  // The last address ends the take instead of wrapping.
                  if (next_addr_q == MAX_ADDR) begin
                     full_d  = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     next_addr_d = next_addr_q + 1'b1;
                     state_d     = S_WAIT;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         lrc_q       <= 1'b0;
         shift_q     <= '0;
         cnt_q       <= '0;
         next_addr_q <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lrc_q       <= lrc_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         next_addr_q <= next_addr_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         full_q      <= full_d;
      end
   end

   assign bus.o_address = addr_q;
   assign bus.o_data    = data_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_full    = full_q;
endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: frames are generated here, and the expected
// SRAM writes are derived per frame from the recording rules.
module tb_aud_recorder;
   localparam int              AW   = 3;
   localparam logic [AW-1:0]   MAXA = 3'd7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   aud_recorder_if #(.ADDR_W(AW)) bus ();

   aud_recorder #(
      .ADDR_W   (AW),
      .MAX_ADDR (MAXA)
   ) dut (
      .i_bclk  (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            at;
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   wr_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;

   // Recording model: active flag, fill address and full flag.
   bit            rec = 1'b0;
   bit            m_full = 1'b0;
   logic [AW-1:0] m_next = '0;
   logic [AW-1:0] h_addr = '0;
   logic [15:0]   h_data = '0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Outputs are compared every cycle: a strobe exactly when a write is
   // due, otherwise address and data holding the last written values.
   always @(negedge clk) begin : cmp
      bit  ev;
      wr_t w;
      if (!rst_n) begin
         exp_q.delete();
         h_addr = '0;
         h_data = '0;
      end
      ev = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
         w = exp_q.pop_front();
         chk("strobe_time", cyc, w.at);
         ev = 1'b1;
         h_addr = w.addr;
         h_data = w.data;
      end
      chk("o_valid", bus.o_valid, ev);
      chk("o_address", bus.o_address, h_addr);
      chk("o_data", bus.o_data, h_data);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic status(string nm);
      chk({nm, "_busy"}, bus.o_busy, rec);
      chk({nm, "_full"}, bus.o_full, m_full);
   endtask

   task automatic pulse_start(bit with_stop);
      bus.i_start = 1'b1;
      bus.i_stop  = with_stop;
      tick();
      bus.i_start = 1'b0;
      bus.i_stop  = 1'b0;
      if (with_stop) begin
         rec = 1'b0;
      end else if (!rec) begin
         rec    = 1'b1;
         m_next = '0;
         m_full = 1'b0;
      end
   endtask

   task automatic pulse_stop();
      bus.i_stop = 1'b1;
      tick();
      bus.i_stop = 1'b0;
      rec = 1'b0;
   endtask

   // One LRCK period: low half with junk, delay slot, nbits data bits,
   // then a high tail. Optional stop, mid-frame pause or reset at bit k.
   task automatic send_frame(logic [15:0] d, bit p_start, bit p_mid,
                             int nbits, int stop_at, int rst_at);
      int  fs;
      int  pad;
      bit  acc;
      bus.i_pause   = p_start;
      bus.i_adclrck = 1'b0;
      for (int i = 0; i < int'($urandom_range(17, 20)); i++) begin
         bus.i_adcdat = 1'($urandom_range(0, 1));
         tick();
      end
      bus.i_adclrck = 1'b1;
      bus.i_adcdat  = 1'($urandom_range(0, 1));
      fs  = cyc + 1;
      acc = rec && !p_start && nbits == 16 && stop_at < 0 && rst_at < 0;
      if (stop_at >= 0) rec = 1'b0;
      if (rst_at >= 0) begin
         rec    = 1'b0;
         m_full = 1'b0;
         m_next = '0;
      end
      if (acc) begin
         // Bit 0 is captured 16 edges after the delay-slot edge.
         exp_q.push_back('{fs + 16, m_next, d});
         if (m_next == MAXA) begin
            m_full = 1'b1;
            rec    = 1'b0;
         end else begin
            m_next = m_next + 1'b1;
         end
      end
      tick();
      for (int k = 0; k < nbits; k++) begin
         bus.i_adcdat = d[15-k];
         bus.i_stop   = (k == stop_at);
         if (p_mid && k == 8) bus.i_pause = 1'b1;
         if (rst_at >= 0 && k == rst_at + 2) rst_n = 1'b1;
         if (k == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_valid", bus.o_valid, 0);
            chk("rst_busy", bus.o_busy, 0);
            chk("rst_full", bus.o_full, 0);
            chk("rst_addr", bus.o_address, 0);
            chk("rst_data", bus.o_data, 0);
         end
         tick();
      end
      bus.i_stop = 1'b0;
      rst_n = 1'b1;
      pad = (nbits == 16) ? int'($urandom_range(1, 4)) : 0;
      for (int i = 0; i < pad; i++) begin
         bus.i_adcdat = 1'($urandom_range(0, 1));
         tick();
      end
      bus.i_adclrck = 1'b0;
   endtask

   task automatic frame(logic [15:0] d);
      send_frame(d, 1'b0, 1'b0, 16, -1, -1);
   endtask

   initial begin
      bus.i_adclrck = 1'b0;
      bus.i_adcdat  = 1'b0;
      bus.i_start   = 1'b0;
      bus.i_pause   = 1'b0;
      bus.i_stop    = 1'b0;
      repeat (3) tick();
      chk("reset_valid", bus.o_valid, 0);
      chk("reset_busy", bus.o_busy, 0);
      chk("reset_full", bus.o_full, 0);
      chk("reset_addr", bus.o_address, 0);
      chk("reset_data", bus.o_data, 0);
      rst_n = 1'b1;
      tick();

      pulse_start(1'b0);
      status("start");
      frame(16'hA5C3);
      chk("basic_data", bus.o_data, 16'hA5C3);
      chk("basic_addr", bus.o_address, 0);
      chk("basic_busy", bus.o_busy, 1);

      pulse_stop();
      pulse_start(1'b0);
      frame(16'h0001);
      frame(16'h8000);
      frame(16'hFFFF);
      chk("consec_data", bus.o_data, 16'hFFFF);
      chk("consec_addr", bus.o_address, 2);

      pulse_stop();
      pulse_start(1'b0);
      send_frame(16'h1111, 1'b0, 1'b1, 16, -1, -1);
      send_frame(16'h2222, 1'b1, 1'b0, 16, -1, -1);
      send_frame(16'h3333, 1'b0, 1'b0, 16, -1, -1);
      send_frame(16'h4444, 1'b0, 1'b0, 16, -1, -1);
      chk("pause_data", bus.o_data, 16'h4444);
      chk("pause_addr", bus.o_address, 2);

      send_frame(16'h5555, 1'b0, 1'b0, 16, 8, -1);
      chk("stop_busy", bus.o_busy, 0);
      chk("stop_addr", bus.o_address, 2);
      chk("stop_data", bus.o_data, 16'h4444);
      pulse_start(1'b0);
      send_frame(16'h6666, 1'b0, 1'b0, 10, -1, -1);
      frame(16'h7777);
      chk("trunc_data", bus.o_data, 16'h7777);
      chk("trunc_addr", bus.o_address, 0);

      pulse_stop();
      pulse_start(1'b0);
      for (int i = 0; i < 9; i++) frame(16'($urandom));
      chk("full_flag", bus.o_full, 1);
      chk("full_busy", bus.o_busy, 0);
      chk("full_addr", bus.o_address, 7);
      pulse_start(1'b0);
      chk("full_cleared", bus.o_full, 0);
      frame(16'hBEEF);
      chk("restart_addr", bus.o_address, 0);
      chk("restart_data", bus.o_data, 16'hBEEF);

      frame(16'h1234);
      send_frame(16'hCAFE, 1'b0, 1'b0, 16, -1, 6);
      status("post_reset");
      frame(16'h0F0F);
      pulse_start(1'b1);
      status("start_stop");
      chk("start_stop_busy", bus.o_busy, 0);

      for (int it = 0; it < 120; it++) begin
         int r;
         r = int'($urandom_range(0, 19));
         if (r < 2) begin
            pulse_stop();
         end else if (r < 4) begin
            pulse_start($urandom_range(0, 3) == 0);
         end else begin
            send_frame(16'($urandom),
                       $urandom_range(0, 4) == 0,
                       $urandom_range(0, 5) == 0,
                       ($urandom_range(0, 7) == 0) ?
                          int'($urandom_range(1, 15)) : 16,
                       ($urandom_range(0, 11) == 0) ?
                          int'($urandom_range(0, 15)) : -1,
                       -1);
         end
         status("rand");
      end

      repeat (30) tick();
      chk("pending_writes", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
